priority_encoder_8to3: RTL

PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

---
 rtl/priority_encoder_8to3.sv | 77 +++++++
 1 files changed

// File: rtl/priority_encoder_8to3.sv
// Sticky 8-bit request collector that offers the highest-priority pending index over valid/ready.
// Capture to pending takes 1 cycle and pending to offer 1 more; a stalled offer holds steady, and each handshake is followed by one idle bubble.
module priority_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] pending,
  output logic       any_pending
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state, state_nxt;
  logic [2:0] code_nxt;
  logic [2:0] top_idx;
  logic [7:0] clr;
  logic [7:0] cap;
  logic [7:0] pending_nxt;

  assign any_pending = |pending;
  assign code_valid  = (state == OFFER);

  // The later loop iteration wins, so scan toward the preferred end.
  always_comb begin
    top_idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (pending[i]) top_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pending[i]) top_idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    clr       = 8'h00;
    case (state)
      IDLE: begin
        if (any_pending) begin
          state_nxt = OFFER;
          code_nxt  = top_idx;
        end
      end
      OFFER: begin
        if (code_ready) begin
          state_nxt = IDLE;
          clr       = 8'h01 << code;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cap = enable ? req : 8'h00;
    // A new capture overrides a same-cycle clear of that bit.
    pending_nxt = (pending & ~clr) | cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code    <= 3'd0;
      pending <= 8'h00;
    end else begin
      state   <= state_nxt;
      code    <= code_nxt;
      pending <= pending_nxt;
    end
  end

endmodule
